// File: rtl/response_packetizer.sv
// Frames NUM_WORDS response-FIFO words into one UART packet:
// header, word count, MSB-first payload bytes and an optional XOR checksum.
module response_packetizer #(
  parameter int                  RESPONSE_BITS = 32,
  parameter int                  DATA_BITS     = 8,
  parameter int                  NUM_WORDS     = 1,
  parameter logic [DATA_BITS-1:0] RESPONSE_ID  = 8'hAB,
  parameter bit                  CHECKSUM_EN   = 1'b1,
  parameter int                  TIMEOUT_BITS  = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [RESPONSE_BITS-1:0] fifo_dout,
  input  logic                     fifo_empty,
  output logic                     fifo_re,
  output logic [DATA_BITS-1:0]     tx_data,
  output logic                     tx_enable,
  input  logic                     tx_busy,
  output logic                     busy,
  output logic                     done,
  output logic                     abort
);

  localparam int                   BPW        = (RESPONSE_BITS + 7) / 8;
  localparam int                   SR_BITS    = BPW * DATA_BITS;
  localparam logic [3:0]           LAST_BYTE  = 4'(BPW - 1);
  localparam logic [DATA_BITS-1:0] WORD_COUNT = DATA_BITS'(NUM_WORDS);

  typedef enum logic [3:0] {
    IDLE,
    HDR,
    LEN,
    FETCH,
    CAPTURE,
    SEND,
    CHK,
    TX_REQ,
    TX_WAIT,
    FIN,
    ABORT
  } state_t;

  state_t                   state, state_next;
  state_t                   ret_state, ret_next;
  logic [DATA_BITS-1:0]     checksum;
  logic [SR_BITS-1:0]       shreg;
  logic [3:0]               byte_idx;
  logic [7:0]               word_cnt;
  logic [TIMEOUT_BITS-1:0]  timeout_cnt;
  logic                     timeout_hit;

  assign timeout_hit = (timeout_cnt == '1);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, matching real flop behaviour.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      ret_state <= IDLE;
    end else begin
      state     <= state_next;
      ret_state <= ret_next;
    end
  end

  // NOTE: every output and next-state value gets a default before the case,
  // so no path through this block can leave one unassigned and infer a latch.
  always_comb begin
    state_next = state;
    ret_next   = ret_state;
    fifo_re    = 1'b0;
    tx_enable  = 1'b0;
    busy       = 1'b1;
    done       = 1'b0;
    abort      = 1'b0;

    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) state_next = HDR;
      end
      HDR: begin
        ret_next   = LEN;
        state_next = TX_REQ;
      end
      LEN: begin
        ret_next   = FETCH;
        state_next = TX_REQ;
      end
      FETCH: begin
        // A timeout at terminal count takes priority over data that shows up
        // on that same cycle, so the read strobe is gated by it too.
        if (timeout_hit) begin
          state_next = ABORT;
        end else if (!fifo_empty) begin
          fifo_re    = 1'b1;
          state_next = CAPTURE;
        end
      end
      CAPTURE: state_next = SEND;
      SEND: begin
        state_next = TX_REQ;
        if (byte_idx != LAST_BYTE)       ret_next = SEND;
        else if (word_cnt != WORD_COUNT) ret_next = FETCH;
        else if (CHECKSUM_EN)            ret_next = CHK;
        else                             ret_next = FIN;
      end
      CHK: begin
        ret_next   = FIN;
        state_next = TX_REQ;
      end
      TX_REQ: begin
        tx_enable = 1'b1;
        if (tx_busy) state_next = TX_WAIT;
      end
      TX_WAIT: begin
        if (!tx_busy) state_next = ret_state;
      end
      FIN: begin
        busy       = 1'b0;
        done       = 1'b1;
        state_next = IDLE;
      end
      ABORT: begin
        busy       = 1'b0;
        abort      = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Datapath: byte staging, payload shifter, checksum and the three counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      tx_data     <= '0;
      checksum    <= '0;
      shreg       <= '0;
      byte_idx    <= '0;
      word_cnt    <= '0;
      timeout_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            checksum    <= '0;
            word_cnt    <= '0;
            timeout_cnt <= '0;
          end
        end
        HDR: tx_data <= RESPONSE_ID;
        LEN: begin
          tx_data  <= WORD_COUNT;
          checksum <= checksum ^ WORD_COUNT;
        end
        FETCH: begin
          if (fifo_re) begin
            timeout_cnt <= '0;
            word_cnt    <= word_cnt + 8'd1;
          end else if (!timeout_hit) begin
            timeout_cnt <= timeout_cnt + TIMEOUT_BITS'(1);
          end
        end
        CAPTURE: begin
          shreg    <= SR_BITS'(fifo_dout);
          byte_idx <= '0;
        end
        SEND: begin
          tx_data  <= shreg[SR_BITS-1 -: DATA_BITS];
          checksum <= checksum ^ shreg[SR_BITS-1 -: DATA_BITS];
          shreg    <= shreg << DATA_BITS;
          byte_idx <= byte_idx + 4'd1;
        end
        CHK: tx_data <= checksum;
        default: ;
      endcase
    end
  end

endmodule
